truth_table_checker: RTL

- Sequential response-side partner to the combinational identity pairs (two expressions s1/s2 over shared operands).
- On start, sweeps every operand combination, drives the operands, samples both expression outputs and builds their truth tables.
- Compares the two truth tables and reports equal/mismatch, mismatch count and first failing row.
- Replaces hand-written per-row $monitor checking in the lab benches with a self-checking block.

---
 rtl/truth_table_checker.sv | 91 +++++++++
 1 files changed

// File: rtl/truth_table_checker.sv
// Sweeps every operand combination of an identity pair, records both truth tables
// and reports whether they agree, how many rows differ and the first differing row.
module truth_table_checker #(
  parameter int N_IN = 2,
  localparam int R = 1 << N_IN
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  output logic [N_IN-1:0] x_out,
  input  logic            s1,
  input  logic            s2,
  output logic            busy,
  output logic            done,
  output logic            equal,
  output logic [R-1:0]    tt1,
  output logic [R-1:0]    tt2,
  output logic [N_IN:0]   mismatch_count,
  output logic [N_IN-1:0] first_fail_row
);

  typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} state_t;

  localparam logic [N_IN:0] LAST_ROW = (N_IN+1)'(R - 1);

  state_t        state;
  logic [N_IN:0] r;
  logic          row_mismatch;

  // The xor goes unknown whenever either response is x/z, so unknowns count as mismatches.
  assign row_mismatch = ((s1 ^ s2) !== 1'b0);

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      r              <= '0;
      x_out          <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      equal          <= 1'b0;
      tt1            <= '0;
      tt2            <= '0;
      mismatch_count <= '0;
      first_fail_row <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state          <= DRIVE;
            r              <= '0;
            x_out          <= '0;
            busy           <= 1'b1;
            done           <= 1'b0;
            equal          <= 1'b0;
            tt1            <= '0;
            tt2            <= '0;
            mismatch_count <= '0;
            first_fail_row <= '0;
          end
        end
        DRIVE: begin
          state <= SAMPLE;
        end
        SAMPLE: begin
          tt1[r[N_IN-1:0]] <= s1;
          tt2[r[N_IN-1:0]] <= s2;
          if (row_mismatch) begin
            mismatch_count <= mismatch_count + 1'b1;
            if (mismatch_count == '0)
              first_fail_row <= r[N_IN-1:0];
          end
          // The last row's verdict is folded into equal here, since the count updates on this same edge.
          if (r == LAST_ROW) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            equal <= (mismatch_count == '0) && !row_mismatch;
          end else begin
            state <= DRIVE;
            r     <= r + 1'b1;
            x_out <= r[N_IN-1:0] + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
